// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing constants for the VGA timing generator.
// Holds the 800x600@72 and 640x480@60 presets plus a total-length helper.
package vga_timing_gen_pkg;

    // 800x600 @ 72 Hz, 50 MHz pixel clock
    localparam int SVGA_H_SYNC   = 120;
    localparam int SVGA_H_BP     = 64;
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 56;
    localparam int SVGA_V_SYNC   = 6;
    localparam int SVGA_V_BP     = 23;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 37;

    // 640x480 @ 60 Hz, 25 MHz pixel clock
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;

    // Full period of one axis: sync + back porch + active + front porch
    function automatic int axis_total(input int s, input int bp,
                                      input int a, input int fp);
        return s + bp + a + fp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with sync level,
// active-window flag and active-relative address.
module vga_axis_counter #(
    parameter int   TOTAL  = 1040,
    parameter int   SYNC   = 120,
    parameter int   BP     = 64,
    parameter int   ACTIVE = 800,
    parameter logic POL    = 1'b0,
    parameter int   CNT_W  = 12
) (
    input  logic             clk50M,
    input  logic             rst_n,
    input  logic             step_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sync_o,
    output logic             act_o,
    output logic [CNT_W-1:0] addr_o
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_LO   = CNT_W'(SYNC + BP);
    localparam logic [CNT_W-1:0] ACT_HI   = CNT_W'(SYNC + BP + ACTIVE);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Advance one position per step, wrapping at the end of the period
    always_comb begin
        cnt_d = cnt_q;
        if (step_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Position register
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign sync_o = (cnt_q < SYNC_END) ? POL : ~POL;
    assign act_o  = (cnt_q >= ACT_LO) && (cnt_q < ACT_HI);
    assign addr_o = act_o ? cnt_q - ACT_LO : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/SVGA raster timing generator: pixel divider, h/v axis counters,
// registered sync/enable/address outputs and line/frame strobes.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   CLK_DIV  = 1,
    parameter int   H_SYNC   = SVGA_H_SYNC,
    parameter int   H_BP     = SVGA_H_BP,
    parameter int   H_ACTIVE = SVGA_H_ACTIVE,
    parameter int   H_FP     = SVGA_H_FP,
    parameter int   V_SYNC   = SVGA_V_SYNC,
    parameter int   V_BP     = SVGA_V_BP,
    parameter int   V_ACTIVE = SVGA_V_ACTIVE,
    parameter int   V_FP     = SVGA_V_FP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CNT_W    = 12
) (
    input  logic             clk50M,
    input  logic             rst_n,
    input  logic             en,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [CNT_W-1:0] h_addr,
    output logic [CNT_W-1:0] v_addr,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en;

    logic [CNT_W-1:0] h_cnt, v_cnt, h_ad, v_ad;
    logic             h_sync, v_sync, h_act, v_act;
    logic             v_step;

    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [CNT_W-1:0] ha_q, ha_d, va_q, va_d;
    logic             ls_q, ls_d, fs_q, fs_d;

    assign pix_en = en && (div_q == '0);
    assign v_step = pix_en && (h_cnt == H_LAST);

    // Divider phase only moves while running, so a freeze keeps the phase
    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    // Pixel-clock divider register
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    vga_axis_counter #(
        .TOTAL  (H_TOTAL),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .POL    (HS_POL),
        .CNT_W  (CNT_W)
    ) u_h (
        .clk50M (clk50M),
        .rst_n  (rst_n),
        .step_i (pix_en),
        .cnt_o  (h_cnt),
        .sync_o (h_sync),
        .act_o  (h_act),
        .addr_o (h_ad)
    );

    vga_axis_counter #(
        .TOTAL  (V_TOTAL),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .POL    (VS_POL),
        .CNT_W  (CNT_W)
    ) u_v (
        .clk50M (clk50M),
        .rst_n  (rst_n),
        .step_i (v_step),
        .cnt_o  (v_cnt),
        .sync_o (v_sync),
        .act_o  (v_act),
        .addr_o (v_ad)
    );

    // Outputs sample the counters on pixel ticks; strobes drop otherwise
    always_comb begin
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        ha_d = ha_q;
        va_d = va_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (pix_en) begin
            hs_d = h_sync;
            vs_d = v_sync;
            de_d = h_act && v_act;
            ha_d = (h_act && v_act) ? h_ad : '0;
            va_d = (h_act && v_act) ? v_ad : '0;
            ls_d = (h_cnt == '0);
            fs_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Output registers
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
            ha_q <= '0;
            va_q <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            ha_q <= ha_d;
            va_q <= va_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign h_addr      = ha_q;
    assign v_addr      = va_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken 10x6 raster.
// Divided-clock instance plus an inverted-polarity undivided instance.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] ha;
        logic [7:0] va;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int   p;
        obs_t exp;
    } vec_t;

    logic clk, rst_n, en;
    logic hs, vs, de, ls, fs;
    logic [7:0] ha, va;
    logic hsp, vsp, dep, lsp, fsp;
    logic [7:0] hap, vap;

    int total = 0;
    int bad = 0;

    obs_t sbq[$];
    obs_t sbp[$];
    obs_t cur, curp;
    int   mp, pp, mdiv;
    vec_t tbl[11];

    vga_timing_gen #(
        .CLK_DIV(2), .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(8)
    ) dut (
        .clk50M(clk), .rst_n(rst_n), .en(en),
        .hs(hs), .vs(vs), .de(de), .h_addr(ha), .v_addr(va),
        .line_start(ls), .frame_start(fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(8)
    ) dut_p (
        .clk50M(clk), .rst_n(rst_n), .en(en),
        .hs(hsp), .vs(vsp), .de(dep), .h_addr(hap), .v_addr(vap),
        .line_start(lsp), .frame_start(fsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic h_s, input logic v_s,
                                input logic d, input int x, input int y,
                                input logic l, input logic f);
        obs_t o;
        o.hs = h_s; o.vs = v_s; o.de = d;
        o.ha = 8'(x); o.va = 8'(y);
        o.ls = l; o.fs = f;
        return o;
    endfunction

    // Expected outputs for global pixel index p on the 10x6 raster
    function automatic obs_t exp_of(input int p, input logic pol);
        int h, v;
        logic d;
        h = p % 10;
        v = (p / 10) % 6;
        d = (h >= 4) && (h < 8) && (v >= 2) && (v < 5);
        return mk((h < 2) ? pol : ~pol, (v < 1) ? pol : ~pol, d,
                  d ? h - 4 : 0, d ? v - 2 : 0, h == 0, h == 0 && v == 0);
    endfunction

    function automatic obs_t obs_d();
        return mk(hs, vs, de, int'(ha), int'(va), ls, fs);
    endfunction

    function automatic obs_t obs_p();
        return mk(hsp, vsp, dep, int'(hap), int'(vap), lsp, fsp);
    endfunction

    task automatic check(input string nm, input obs_t a, input obs_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t got hs=%b vs=%b de=%b ha=%0d va=%0d ls=%b fs=%b want hs=%b vs=%b de=%b ha=%0d va=%0d ls=%b fs=%b",
                     nm, $time, a.hs, a.vs, a.de, a.ha, a.va, a.ls, a.fs,
                     e.hs, e.vs, e.de, e.ha, e.va, e.ls, e.fs);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got %0d want %0d", nm, a, e);
        end
    endtask

    task automatic model_reset();
        mp = 0; pp = 0; mdiv = 0;
        cur  = mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        curp = mk(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // One clock: predict both instances, push, then pop and compare
    task automatic tick();
        obs_t e, ep;
        if (en) begin
            if (mdiv == 0) begin
                cur = exp_of(mp, 1'b0);
                mp++;
            end else begin
                cur.ls = 1'b0; cur.fs = 1'b0;
            end
            mdiv = 1 - mdiv;
            curp = exp_of(pp, 1'b1);
            pp++;
        end else begin
            cur.ls = 1'b0; cur.fs = 1'b0;
            curp.ls = 1'b0; curp.fs = 1'b0;
        end
        sbq.push_back(cur);
        sbp.push_back(curp);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        ep = sbp.pop_front();
        check("sb_div2", obs_d(), e);
        check("sb_pol1", obs_p(), ep);
    endtask

    // Assert reset between edges, check it took effect with no edge
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_div2", obs_d(), mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0));
        check("arst_pol1", obs_p(), mk(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        model_reset();
    endtask

    initial begin
        int edges, last_fs, last_fsp, decnt, guard;
        tbl[0]  = '{0,  mk(0, 0, 0, 0, 0, 1, 1)};
        tbl[1]  = '{4,  mk(1, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{11, mk(0, 1, 0, 0, 0, 0, 0)};
        tbl[3]  = '{24, mk(1, 1, 1, 0, 0, 0, 0)};
        tbl[4]  = '{27, mk(1, 1, 1, 3, 0, 0, 0)};
        tbl[5]  = '{28, mk(1, 1, 0, 0, 0, 0, 0)};
        tbl[6]  = '{35, mk(1, 1, 1, 1, 1, 0, 0)};
        tbl[7]  = '{47, mk(1, 1, 1, 3, 2, 0, 0)};
        tbl[8]  = '{50, mk(0, 1, 0, 0, 0, 1, 0)};
        tbl[9]  = '{60, mk(0, 0, 0, 0, 0, 1, 1)};
        tbl[10] = '{61, mk(0, 0, 0, 0, 0, 0, 0)};

        rst_n = 1'b0;
        en = 1'b0;
        #12;
        check("rst_div2", obs_d(), mk(1, 1, 0, 0, 0, 0, 0));
        check("rst_pol1", obs_p(), mk(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b1;

        // Pixel p of the divided instance is loaded on edge 2p+1
        edges = 0;
        foreach (tbl[i]) begin
            while (edges < 2 * tbl[i].p + 1) begin
                @(posedge clk);
                edges++;
            end
            #1;
            check($sformatf("tbl_p%0d", tbl[i].p), obs_d(), tbl[i].exp);
        end

        async_reset();

        // Free run: frame periods and de clocks per frame
        last_fs = 0; last_fsp = 0; decnt = 0;
        for (int i = 1; i <= 130; i++) begin
            tick();
            if (fs) begin
                if (last_fs > 0) check_int("fs_period_div2", i - last_fs, 120);
                last_fs = i;
            end
            if (fsp) begin
                if (last_fsp > 0) check_int("fs_period_pol1", i - last_fsp, 60);
                last_fsp = i;
            end
            if (de && i <= 120) decnt++;
        end
        check_int("de_clks_frame", decnt, 24);

        // Freeze mid-line on an active pixel, then resume
        guard = 0;
        while (!(mp % 60 == 36 && mdiv == 1) && guard < 200) begin
            tick();
            guard++;
        end
        check_int("freeze_reach", guard < 200 ? 1 : 0, 1);
        en = 1'b0;
        repeat (50) tick();
        en = 1'b1;
        repeat (40) tick();

        // Irregular run/freeze pattern
        for (int i = 0; i < 100; i++) begin
            en = ($urandom_range(0, 3) != 0);
            tick();
        end
        en = 1'b1;
        repeat (7) tick();

        // Reset mid-frame; first edge afterwards starts a frame
        async_reset();
        tick();
        check_int("restart_fs", int'(fs), 1);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
